prog_mem_loader: RTL and testbench
==================================

Name: prog_mem_loader

Overview:
- Writer side of the TD4 program memory. The CPU only reads the program store (4-bit address in, 8-bit instruction out).
- This block fills a 16x8 program store from a byte stream (UART-RX or host bridge) using a valid/ready handshake, then checks a trailing checksum.
- On a good checksum it releases the CPU through cpu_run. The read port matches the existing program-store interface, so it drops in where the CPU fetches instructions.

Parameters:
- ADDR_W, 4, program address width
- DATA_W, 8, instruction width
- DEPTH, 16, number of program words (2**ADDR_W)
- TIMEOUT, 1024, maximum idle cycles between accepted bytes during a load before aborting

Ports:
- clk  in  1  system clock, rising edge
- n_reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins a load
- in_data  in  DATA_W  incoming program byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts a byte this cycle
- rd_addr  in  ADDR_W  CPU fetch address
- rd_data  out  DATA_W  instruction at rd_addr, combinational
- busy  out  1  load in progress
- done  out  1  last load completed with a good checksum
- error  out  1  last load failed (checksum or timeout)
- cpu_run  out  1  CPU enable; high only in DONE
- wr_count  out  ADDR_W+1  number of program bytes written in the current load (0..16)

Behaviour:
- Reset (asynchronous, n_reset=0):
  - state=IDLE
  - all memory words=0x00
  - in_ready, busy, done, error, cpu_run = 0
  - wr_count=0, checksum accumulator=0, timer=0
- States: IDLE, LOAD, CHECK, DONE, ERROR. Every transition is registered on the rising edge of clk.
- Handshake: a byte is accepted when in_valid and in_ready are both high on a clock edge. in_data must be held until it is accepted. in_ready depends only on state; it has no combinational path from in_valid.
- IDLE / DONE / ERROR with start=1:
  - next state LOAD
  - wr_count=0, sum=0, timer=0
  - done, error and cpu_run clear on the same edge
- start is ignored in LOAD and CHECK.
- LOAD:
  - in_ready=1, busy=1
  - on accept: mem[wr_count[ADDR_W-1:0]] <= in_data; sum <= (sum + in_data) mod 256; wr_count++
  - the accept that brings wr_count to 16 moves the state to CHECK
- CHECK:
  - in_ready=1, busy=1
  - the next accepted byte is the checksum and is not stored
  - if (sum + byte) mod 256 == 0, go to DONE; otherwise go to ERROR
- DONE: done=1, cpu_run=1, in_ready=0, busy=0. Memory is frozen.
- ERROR: error=1, cpu_run=0, in_ready=0. Memory keeps the partially written contents.
- Timeout:
  - in LOAD and CHECK, timer increments on every cycle without an accept and clears on accept
  - when timer reaches TIMEOUT-1 with no accept, the next state is ERROR
  - if an accept happens on that same cycle, the accept wins and the timer clears
- Read port:
  - rd_data = mem[rd_addr] combinationally, in every state
  - a write to address A on edge N is visible on rd_data from just after edge N
  - no read/write collision hazard beyond that
- Boundary conditions:
  - wr_count never exceeds 16; the write pointer does not wrap within a load
  - a fresh start restarts the write pointer at address 0
  - reset asserted mid-load aborts immediately, clears memory and drops cpu_run; no partial state survives
- Latency: cpu_run rises on the same edge as the checksum accept, which is the 17th accepted byte.

Decomposition:
- Shared package td4_pkg:
  - ADDR_W, DATA_W and DEPTH constants
  - loader state enum (IDLE, LOAD, CHECK, DONE, ERROR)
  - the checksum rule: two's complement of the mod-256 byte sum
- One sub-module, prog_mem:
  - DEPTH x DATA_W register file
  - one synchronous write port (we, waddr, wdata)
  - one combinational read port
  - asynchronous clear on n_reset
- The FSM, counters and timer stay in prog_mem_loader.

Test Plan:
- Good load, no stalls:
  - stimulus: start pulse, then bytes 0x00..0x0F back-to-back, then checksum 0x88 (sum 0x78)
  - response: done=1, cpu_run=1, error=0, wr_count=16; rd_addr 0..15 returns 0x00..0x0F
- Bad checksum:
  - stimulus: the same 16 bytes followed by checksum 0x87
  - response: error=1, cpu_run=0, done=0; rd_addr=5 still returns 0x05
- Timeout:
  - stimulus: start, 3 bytes, then in_valid held low for 1024 cycles
  - response: error=1 after exactly TIMEOUT cycles; wr_count=3
  - a second variant gives a byte at cycle TIMEOUT-1 and must stay in LOAD
- Start mid-load and gaps:
  - stimulus: in_valid toggles with random gaps shorter than TIMEOUT; a start pulse is injected after byte 7
  - response: start ignored, wr_count continues 8..16; good checksum ends in done=1
- Reset mid-load:
  - stimulus: n_reset pulled low asynchronously (not aligned to clk) after byte 10
  - response: all outputs 0 immediately; rd_data=0x00 for every address
- Reload after DONE:
  - stimulus: a second start, then 16 bytes of 0xFF and checksum 0x10
  - response: cpu_run drops on the start edge, then done=1 and rd_addr=0 returns 0xFF

Source files
------------

// File: rtl/td4_pkg.sv
// ============================================================================
// Module   : td4_pkg
// Purpose  : Shared constants, loader state type and checksum rule for TD4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package td4_pkg;

    localparam int TD4_ADDR_W = 4;
    localparam int TD4_DATA_W = 8;
    localparam int TD4_DEPTH  = 2 ** TD4_ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_t;

    // The trailing byte must make the mod-256 total of the image zero.
    function automatic logic [TD4_DATA_W-1:0] checksum_of(input logic [TD4_DATA_W-1:0] sum);
        return ~sum + TD4_DATA_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/prog_mem.sv
// ============================================================================
// Module   : prog_mem
// Purpose  : DEPTH x DATA_W program store, one sync write, one comb read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_mem
    import td4_pkg::*;
#(
    parameter int ADDR_W = TD4_ADDR_W,
    parameter int DATA_W = TD4_DATA_W,
    parameter int DEPTH  = TD4_DEPTH
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/prog_mem_loader.sv
// ============================================================================
// Module   : prog_mem_loader
// Purpose  : Fills the TD4 program store from a byte stream, checks checksum,
//            and releases the CPU on success.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_mem_loader
    import td4_pkg::*;
#(
    parameter int ADDR_W  = TD4_ADDR_W,
    parameter int DATA_W  = TD4_DATA_W,
    parameter int DEPTH   = TD4_DEPTH,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_run,
    output logic [ADDR_W:0]   wr_count
);

    localparam int           TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]  CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

    loader_state_t     r_state;
    loader_state_t     w_next_state;
    logic [DATA_W-1:0] r_sum;
    logic [TMR_W-1:0]  r_timer;
    logic [ADDR_W:0]   r_wr_count;

    logic w_accept;
    logic w_timeout;
    logic w_restart;
    logic w_sum_ok;
    logic w_we;

    assign w_accept  = in_valid && in_ready;
    assign w_timeout = !w_accept && (r_timer == TMR_LAST);
    assign w_restart = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                 (r_state == ST_ERROR));
    assign w_sum_ok  = (in_data == checksum_of(r_sum));
    assign w_we      = w_accept && (r_state == ST_LOAD);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept && (r_wr_count == CNT_LAST)) begin
                    w_next_state = ST_CHECK;
                end else if (w_timeout) begin
                    w_next_state = ST_ERROR;
                end
            end
            ST_CHECK: begin
                if (w_accept) begin
                    w_next_state = w_sum_ok ? ST_DONE : ST_ERROR;
                end else if (w_timeout) begin
                    w_next_state = ST_ERROR;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_run  = 1'b0;
        case (r_state)
            ST_LOAD, ST_CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_DONE: begin
                done    = 1'b1;
                cpu_run = 1'b1;
            end
            ST_ERROR: error = 1'b1;
            default: ;
        endcase
    end

    // The inactivity timer only runs while bytes are expected.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sum      <= '0;
            r_timer    <= '0;
            r_wr_count <= '0;
        end else if (w_restart) begin
            r_sum      <= '0;
            r_timer    <= '0;
            r_wr_count <= '0;
        end else if ((r_state == ST_LOAD) || (r_state == ST_CHECK)) begin
            if (w_accept || w_timeout) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TMR_W'(1);
            end
            if (w_we) begin
                r_sum      <= r_sum + in_data;
                r_wr_count <= r_wr_count + (ADDR_W + 1)'(1);
            end
        end
    end

    assign wr_count = r_wr_count;

    prog_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_prog_mem (
        .clk     (clk),
        .n_reset (n_reset),
        .we      (w_we),
        .waddr   (r_wr_count[ADDR_W-1:0]),
        .wdata   (in_data),
        .raddr   (rd_addr),
        .rdata   (rd_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_prog_mem_loader.sv
// ============================================================================
// Module   : tb_prog_mem_loader
// Purpose  : Directed self-checking bench for prog_mem_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_mem_loader;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       error;
    logic       cpu_run;
    logic [4:0] wr_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] sum;

    always #5 clk = ~clk;

    prog_mem_loader #(
        .ADDR_W  (4),
        .DATA_W  (8),
        .DEPTH   (16),
        .TIMEOUT (1024)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_run  (cpu_run),
        .wr_count (wr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offers a byte and returns 1 ns after the edge that accepts it.
    task automatic send(input logic [7:0] b);
        int n;
        n        = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("send_ready_wait", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_outputs(input string tag, input logic [4:0] st);
        // st bits: {in_ready, busy, done, error, cpu_run}
        chk(tag, {27'd0, in_ready, busy, done, error, cpu_run}, {27'd0, st});
    endtask

    initial begin
        n_reset  = 1'b0;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        rd_addr  = 4'd0;
        #12;
        chk_outputs("reset_flags", 5'b00000);
        chk("reset_wr_count", 32'(wr_count), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'h00);
        @(negedge clk);
        n_reset = 1'b1;
        @(posedge clk); #1;
        chk_outputs("idle_flags", 5'b00000);

        // Good load, no stalls.
        pulse_start();
        chk_outputs("load_flags", 5'b11000);
        for (int i = 0; i < 16; i++) send(8'(i));
        chk_outputs("check_flags", 5'b11000);
        chk("check_wr_count", 32'(wr_count), 32'd16);
        send(8'h88);
        chk_outputs("good_done_flags", 5'b00101);
        chk("good_wr_count", 32'(wr_count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            chk($sformatf("good_rd_%0d", i), 32'(rd_data), 32'(i));
        end

        // Bad checksum.
        pulse_start();
        chk_outputs("restart_flags", 5'b11000);
        for (int i = 0; i < 16; i++) send(8'(i));
        send(8'h87);
        chk_outputs("bad_sum_flags", 5'b00010);
        rd_addr = 4'd5;
        #1;
        chk("bad_sum_rd5", 32'(rd_data), 32'h05);

        // Timeout after exactly 1024 idle cycles.
        pulse_start();
        send(8'hA1); send(8'hA2); send(8'hA3);
        repeat (1023) @(posedge clk);
        #1;
        chk_outputs("timeout_1023_flags", 5'b11000);
        @(posedge clk); #1;
        chk_outputs("timeout_flags", 5'b00010);
        chk("timeout_wr_count", 32'(wr_count), 32'd3);

        // Byte on the last allowed cycle keeps the load alive.
        pulse_start();
        sum = 8'h00;
        for (int i = 0; i < 3; i++) begin
            send(8'h11 * 8'(i + 1));
            sum = sum + 8'h11 * 8'(i + 1);
        end
        repeat (1023) @(posedge clk);
        #1;
        send(8'h44);
        sum = sum + 8'h44;
        chk_outputs("late_byte_flags", 5'b11000);
        chk("late_byte_wr_count", 32'(wr_count), 32'd4);
        @(posedge clk); #1;
        chk_outputs("late_byte_next_flags", 5'b11000);
        for (int i = 4; i < 16; i++) begin
            send(8'(i * 5));
            sum = sum + 8'(i * 5);
        end
        send(~sum + 8'd1);
        chk_outputs("late_byte_done_flags", 5'b00101);
        rd_addr = 4'd3;
        #1;
        chk("late_byte_rd3", 32'(rd_data), 32'h44);

        // Random gaps and a start pulse in mid-load.
        pulse_start();
        sum = 8'h00;
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            send(8'h30 + 8'(i * 3));
            sum = sum + 8'h30 + 8'(i * 3);
            if (i == 7) begin
                pulse_start();
                chk("midstart_wr_count", 32'(wr_count), 32'd8);
                chk_outputs("midstart_flags", 5'b11000);
            end
        end
        chk("gaps_wr_count", 32'(wr_count), 32'd16);
        send(~sum + 8'd1);
        chk_outputs("gaps_done_flags", 5'b00101);
        rd_addr = 4'd15;
        #1;
        chk("gaps_rd15", 32'(rd_data), 32'h5D);

        // Reload after DONE.
        pulse_start();
        chk_outputs("reload_start_flags", 5'b11000);
        chk("reload_wr_count", 32'(wr_count), 32'd0);
        for (int i = 0; i < 16; i++) send(8'hFF);
        send(8'h10);
        chk_outputs("reload_done_flags", 5'b00101);
        rd_addr = 4'd0;
        #1;
        chk("reload_rd0", 32'(rd_data), 32'hFF);

        // Asynchronous reset in mid-load.
        pulse_start();
        for (int i = 0; i < 10; i++) send(8'hC0 + 8'(i));
        chk("pre_reset_wr_count", 32'(wr_count), 32'd10);
        #3;
        n_reset = 1'b0;
        #1;
        chk_outputs("async_reset_flags", 5'b00000);
        chk("async_reset_wr_count", 32'(wr_count), 32'd0);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #0.1;
            chk($sformatf("async_reset_rd_%0d", i), 32'(rd_data), 32'h00);
        end
        @(negedge clk);
        n_reset = 1'b1;
        @(posedge clk); #1;
        chk_outputs("post_reset_flags", 5'b00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
